// File: rtl/fft_r2_iter_stream_pkg.sv
// Shared definitions for the iterative radix-2 streaming FFT: FSM encoding,
// default size and the load-address bit reversal.
package fft_r2_iter_stream_pkg;

    localparam int DEFAULT_LOG2N = 4;
    localparam int MAX_LOG2N     = 8;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    // Reverses the low `bits` bits of v; upper bits come back zero.
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] v, input int bits);
        logic [MAX_LOG2N-1:0] r;
        r = '0;
        for (int b = 0; b < MAX_LOG2N; b++) begin
            if (b < bits) r[bits-1-b] = v[b];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_r2_iter_stream_if.sv
// Sample-in / spectrum-out stream pair. master = sample source and spectrum
// consumer side, slave = the FFT block.
interface fft_r2_iter_stream_if #(parameter int DW = 16);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_r;
    logic signed [DW-1:0] in_i;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_r;
    logic signed [DW-1:0] out_i;
    logic                 out_last;

    modport master (
        output in_valid, in_r, in_i, out_ready,
        input  in_ready, out_valid, out_r, out_i, out_last
    );

    modport slave (
        input  in_valid, in_r, in_i, out_ready,
        output in_ready, out_valid, out_r, out_i, out_last
    );
endinterface

// File: rtl/fft_r2_iter_stream_twiddle_rom.sv
// Combinational twiddle table W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), k < N/2,
// Q1.(TW-1), built at elaboration; +1.0 saturates to the largest positive code.
module fft_twiddle_rom #(
    parameter int LOG2N = 4,
    parameter int TW    = 16
) (
    input  logic [LOG2N-2:0]     k,
    output logic signed [TW-1:0] w_r,
    output logic signed [TW-1:0] w_i
);
    localparam int NH = 1 << (LOG2N - 1);
    typedef logic [NH-1:0][2*TW-1:0] tab_t;

    function automatic longint quant(input real x);
        longint v, hi;
        hi = (longint'(1) << (TW - 1)) - 1;
        v  = longint'($floor(x + 0.5));
        if (v > hi) v = hi;
        if (v < -hi - 1) v = -hi - 1;
        return v;
    endfunction

    function automatic tab_t gen_tab();
        tab_t t;
        real  ang, scale;
        scale = real'(longint'(1) << (TW - 1));
        for (int i = 0; i < NH; i++) begin
            ang  = 3.141592653589793 * real'(i) / real'(NH);
            t[i] = {TW'(quant($cos(ang) * scale)), TW'(quant(-$sin(ang) * scale))};
        end
        return t;
    endfunction

    localparam tab_t TAB = gen_tab();

    assign w_r = TAB[k][2*TW-1:TW];
    assign w_i = TAB[k][TW-1:0];
endmodule

// File: rtl/fft_r2_iter_stream.sv
// Iterative in-place radix-2 DIT FFT, one butterfly per clock, 1/N scaling.
// Define FFT_INVERSE_EN to add the per-frame `inverse` port (conjugate twiddles).
module fft_r2_iter_stream
    import fft_r2_iter_stream_pkg::*;
#(
    parameter int LOG2N = DEFAULT_LOG2N,
    parameter int DW    = 16,
    parameter int TW    = 16
) (
    input  logic clk,
    input  logic rst_n,
`ifdef FFT_INVERSE_EN
    input  logic inverse,
`endif
    fft_r2_iter_stream_if.slave bus,
    output logic busy
);
    localparam int         N        = 1 << LOG2N;
    localparam logic [3:0] LAST_STG = 4'(LOG2N - 1);

    state_t               state;
    logic [LOG2N-1:0]     ncnt, ucnt;
    logic [LOG2N-2:0]     j;
    logic [3:0]           stg;
    logic signed [DW-1:0] mem_r [N];
    logic signed [DW-1:0] mem_i [N];

    logic                 hs_in;
    logic [LOG2N-1:0]     ld_addr;
    logic [LOG2N-1:0]     h, lo_mask, jx, j_lo, addr_a, addr_b, k_full;
    logic [LOG2N-2:0]     tw_k;
    logic signed [TW-1:0] rom_wr, rom_wi, wr, wi;

    assign hs_in   = bus.in_valid & bus.in_ready & (state == LOAD);
    assign ld_addr = LOG2N'(bitrev(MAX_LOG2N'(ncnt), LOG2N));

    // Pair (a, a+h) is j with a zero inserted at bit s; k is j mod h scaled to N.
    always_comb begin
        h       = LOG2N'(1) << stg;
        lo_mask = h - LOG2N'(1);
        jx      = LOG2N'(j);
        j_lo    = jx & lo_mask;
        addr_a  = ((jx & ~lo_mask) << 1) | j_lo;
        addr_b  = addr_a | h;
        k_full  = j_lo << (LAST_STG - stg);
        tw_k    = k_full[LOG2N-2:0];
    end

    fft_twiddle_rom #(.LOG2N(LOG2N), .TW(TW)) u_rom (
        .k   (tw_k),
        .w_r (rom_wr),
        .w_i (rom_wi)
    );

`ifdef FFT_INVERSE_EN
    localparam logic signed [TW-1:0] W_MAX = {1'b0, {(TW-1){1'b1}}};
    localparam logic signed [TW-1:0] W_MIN = {1'b1, {(TW-1){1'b0}}};
    logic inv_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    inv_q <= 1'b0;
        else if (hs_in && ncnt == '0)  inv_q <= inverse;
    end

    // Conjugating -1.0j would need +1.0, which saturates like the cosine does.
    always_comb begin
        wr = rom_wr;
        wi = rom_wi;
        if (inv_q) wi = (rom_wi == W_MIN) ? W_MAX : -rom_wi;
    end
`else
    assign wr = rom_wr;
    assign wi = rom_wi;
`endif

    logic signed [DW-1:0]    ar, ai, br, bi;
    logic signed [DW+TW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [DW+TW:0]   m_r, m_i, m_rs, m_is;
    logic signed [DW+1:0]    p_r, p_i;
    logic signed [DW+2:0]    s_ar, s_ai, s_br, s_bi;
    logic signed [DW-1:0]    na_r, na_i, nb_r, nb_i;

    always_comb begin
        ar   = mem_r[addr_a];
        ai   = mem_i[addr_a];
        br   = mem_r[addr_b];
        bi   = mem_i[addr_b];
        p_rr = (DW+TW)'(br) * (DW+TW)'(wr);
        p_ii = (DW+TW)'(bi) * (DW+TW)'(wi);
        p_ri = (DW+TW)'(br) * (DW+TW)'(wi);
        p_ir = (DW+TW)'(bi) * (DW+TW)'(wr);
        m_r  = (DW+TW+1)'(p_rr) - (DW+TW+1)'(p_ii);
        m_i  = (DW+TW+1)'(p_ri) + (DW+TW+1)'(p_ir);
        m_rs = m_r >>> (TW - 1);
        m_is = m_i >>> (TW - 1);
        p_r  = m_rs[DW+1:0];
        p_i  = m_is[DW+1:0];
        // W^0 is only 1-2^-(TW-1) in the table; pass B through exactly instead.
        if (tw_k == '0) begin
            p_r = (DW+2)'(br);
            p_i = (DW+2)'(bi);
        end
        s_ar = (DW+3)'(ar) + (DW+3)'(p_r);
        s_ai = (DW+3)'(ai) + (DW+3)'(p_i);
        s_br = (DW+3)'(ar) - (DW+3)'(p_r);
        s_bi = (DW+3)'(ai) - (DW+3)'(p_i);
        na_r = s_ar[DW:1];
        na_i = s_ai[DW:1];
        nb_r = s_br[DW:1];
        nb_i = s_bi[DW:1];
    end

    always_ff @(posedge clk) begin
        if (hs_in) begin
            mem_r[ld_addr] <= bus.in_r;
            mem_i[ld_addr] <= bus.in_i;
        end else if (state == COMPUTE) begin
            mem_r[addr_a] <= na_r;
            mem_i[addr_a] <= na_i;
            mem_r[addr_b] <= nb_r;
            mem_i[addr_b] <= nb_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= LOAD;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_r     <= '0;
            bus.out_i     <= '0;
            busy          <= 1'b0;
            ncnt          <= '0;
            ucnt          <= '0;
            j             <= '0;
            stg           <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (hs_in) begin
                        ncnt <= ncnt + 1'b1;
                        if (ncnt == LOG2N'(N - 1)) begin
                            state        <= COMPUTE;
                            bus.in_ready <= 1'b0;
                            busy         <= 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (j == '1) begin
                        j <= '0;
                        if (stg == LAST_STG) begin
                            stg   <= '0;
                            state <= UNLOAD;
                        end else begin
                            stg <= stg + 1'b1;
                        end
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                UNLOAD: begin
                    // The first pass through here only primes bin 0 into the output regs.
                    if (!bus.out_valid || bus.out_ready) begin
                        if (bus.out_valid && bus.out_last) begin
                            state         <= LOAD;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            bus.in_ready  <= 1'b1;
                            busy          <= 1'b0;
                        end else begin
                            bus.out_valid <= 1'b1;
                            bus.out_r     <= mem_r[ucnt];
                            bus.out_i     <= mem_i[ucnt];
                            bus.out_last  <= (ucnt == LOG2N'(N - 1));
                            ucnt          <= ucnt + 1'b1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_r2_iter_stream.sv
// Directed bench for fft_r2_iter_stream (N=16): impulse, DC, ramp, backpressure,
// tone and mid-compute reset, with a bit-exact model for the irregular frames.
module tb_fft_r2_iter_stream;
    localparam real PI = 3.141592653589793;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
`ifdef FFT_INVERSE_EN
    logic inverse = 1'b0;
`endif

    fft_r2_iter_stream_if #(.DW(16)) bus ();

    fft_r2_iter_stream #(.LOG2N(4), .DW(16), .TW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef FFT_INVERSE_EN
        .inverse (inverse),
`endif
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;
    int xr[16], xi[16], er[16], ei[16], gr[16], gi[16];
    bit gl[16];
    int lat;

    task automatic chk(input string tag, input longint obs, input longint exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input longint obs, input longint exp, input longint tol);
        ncmp++;
        assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    function automatic longint rnd(input real x);
        return longint'($floor(x + 0.5));
    endfunction

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int brev4(input int n);
        int r = 0;
        for (int b = 0; b < 4; b++) if (n[b]) r |= 1 << (3 - b);
        return r;
    endfunction

    // Reference: bit-reversed load, then groups of 2h with span h per stage.
    function automatic void model(input bit inv);
        longint ar[16], ai[16];
        for (int n = 0; n < 16; n++) begin
            ar[brev4(n)] = xr[n];
            ai[brev4(n)] = xi[n];
        end
        for (int s = 0; s < 4; s++) begin
            int h = 1 << s;
            for (int g = 0; g < 16; g += 2 * h) begin
                for (int m = 0; m < h; m++) begin
                    int k = m * (16 / (2 * h));
                    int ia = g + m;
                    int ib = g + m + h;
                    longint wr, wi, pr, pi, tr, ti;
                    wr = sat16(rnd($cos(2.0 * PI * k / 16.0) * 32768.0));
                    wi = -rnd($sin(2.0 * PI * k / 16.0) * 32768.0);
                    if (inv) wi = -wi;
                    wi = sat16(wi);
                    if (k == 0) begin
                        pr = ar[ib];
                        pi = ai[ib];
                    end else begin
                        pr = (ar[ib] * wr - ai[ib] * wi) >>> 15;
                        pi = (ar[ib] * wi + ai[ib] * wr) >>> 15;
                    end
                    tr = ar[ia];
                    ti = ai[ia];
                    ar[ia] = (tr + pr) >>> 1;
                    ai[ia] = (ti + pi) >>> 1;
                    ar[ib] = (tr - pr) >>> 1;
                    ai[ib] = (ti - pi) >>> 1;
                end
            end
        end
        for (int n = 0; n < 16; n++) begin
            er[n] = int'(ar[n]);
            ei[n] = int'(ai[n]);
        end
    endfunction

    task automatic send_frame(input bit hold_valid);
        int t;
        for (int n = 0; n < 16; n++) begin
            bus.in_valid = 1'b1;
            bus.in_r = 16'(xr[n]);
            bus.in_i = 16'(xi[n]);
            t = 0;
            while (!bus.in_ready && t < 200) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 200) chk("in_ready_timeout", t, 0);
            @(posedge clk); #1;
        end
        if (!hold_valid) bus.in_valid = 1'b0;
    endtask

    task automatic collect(input bit bp);
        int idx = 0;
        int guard = 0;
        bit hold = 0;
        bit rdy;
        int hr = 0, hi = 0;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        while (idx < 16 && guard < 2000) begin
            if (bp) chk("in_ready_busy", bus.in_ready, 0);
            if (hold) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_r", int'(bus.out_r), hr);
                chk("stall_i", int'(bus.out_i), hi);
            end
            if (bus.out_valid) begin
                rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.out_ready = rdy;
                if (rdy) begin
                    gr[idx] = int'(bus.out_r);
                    gi[idx] = int'(bus.out_i);
                    gl[idx] = bus.out_last;
                    idx++;
                    hold = 0;
                end else begin
                    hold = 1;
                    hr = int'(bus.out_r);
                    hi = int'(bus.out_i);
                end
            end else begin
                bus.out_ready = 1'b0;
            end
            @(posedge clk); #1;
            guard++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        chk("bins_received", idx, 16);
        chk("in_ready_after_last", bus.in_ready, 1);
        chk("out_valid_after_last", bus.out_valid, 0);
    endtask

    task automatic check_model(input string tag);
        for (int n = 0; n < 16; n++) begin
            chk($sformatf("%s_r[%0d]", tag, n), gr[n], er[n]);
            chk($sformatf("%s_i[%0d]", tag, n), gi[n], ei[n]);
            chk($sformatf("%s_last[%0d]", tag, n), gl[n], (n == 15));
        end
    endtask

    task automatic check_tone(input string tag);
        for (int n = 0; n < 16; n++) begin
            chk_tol($sformatf("%s_r[%0d]", tag, n), gr[n], (n == 1 || n == 15) ? 8192 : 0, 2);
            chk_tol($sformatf("%s_i[%0d]", tag, n), gi[n], 0, 2);
        end
    endtask

    task automatic impulse_frame();
        for (int n = 0; n < 16; n++) begin
            xr[n] = 0;
            xi[n] = 0;
            er[n] = 16;
            ei[n] = 0;
        end
        xr[0] = 256;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_r = '0;
        bus.in_i = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_r", int'(bus.out_r), 0);
        chk("rst_out_i", int'(bus.out_i), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Impulse 0x100 at n=0 -> every bin 0x10
        impulse_frame();
        send_frame(0);
        collect(0);
        chk("imp_latency", lat, 33);
        check_model("imp");

        // DC 0x400 -> bin0 0x400, rest 0
        for (int n = 0; n < 16; n++) begin
            xr[n] = 1024;
            xi[n] = 0;
            er[n] = (n == 0) ? 1024 : 0;
            ei[n] = 0;
        end
        send_frame(0);
        collect(0);
        check_model("dc");

        // Ramp n*0x100*(1+j): bin0 = 0x780+j0x780
        for (int n = 0; n < 16; n++) begin
            xr[n] = n * 256;
            xi[n] = n * 256;
        end
        model(0);
        send_frame(0);
        collect(0);
        chk("ramp_latency", lat, 33);
        chk("ramp_bin0_r", gr[0], 32'h0780);
        chk("ramp_bin0_i", gi[0], 32'h0780);
        check_model("ramp");

        // Random backpressure, in_valid left high through compute and unload
        for (int n = 0; n < 16; n++) begin
            xr[n] = n * 291 - 2048;
            xi[n] = -n * 80 + ((n % 3) * 700);
        end
        model(0);
        send_frame(1);
        collect(1);
        check_model("bp");

        // Tone 0x4000*cos(2*pi*n/16): energy 0x2000 in bins 1 and 15
        for (int n = 0; n < 16; n++) begin
            xr[n] = int'(rnd(16384.0 * $cos(2.0 * PI * n / 16.0)));
            xi[n] = 0;
        end
        send_frame(0);
        collect(0);
        check_tone("tone");
`ifdef FFT_INVERSE_EN
        inverse = 1'b1;
        send_frame(0);
        inverse = 1'b0;
        collect(0);
        check_tone("itone");
`endif

        // Reset ten cycles into COMPUTE aborts the frame
        impulse_frame();
        send_frame(0);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        impulse_frame();
        send_frame(0);
        collect(0);
        chk("post_rst_latency", lat, 33);
        check_model("post_rst_imp");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
